// File: rtl/intmul_32.sv
// Pipelined 32x32 -> 64-bit unsigned multiplier, delivering the modulus q aligned with D.
// Define INTMUL_OUT_REG_EN to add a fourth output register stage (latency 4 instead of 3).
module intmul_32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        valid_in,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] q,
   output logic        valid_out,
   output logic [63:0] D,
   output logic [31:0] q_out
);

   function automatic logic [31:0] mul16(input logic [15:0] x, input logic [15:0] y);
      return {16'd0, x} * {16'd0, y};
   endfunction

   logic [31:0] pll_p0, plh_p0, phl_p0, phh_p0, q_p0;
   logic        vld_p0;
   logic [32:0] mid_p1;
   logic [31:0] pll_p1, phh_p1, q_p1;
   logic        vld_p1;
   logic [63:0] d_p2;
   logic [31:0] q_p2;
   logic        vld_p2;

   // Stage p0: four 16x16 partial products
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pll_p0 <= '0;
         plh_p0 <= '0;
         phl_p0 <= '0;
         phh_p0 <= '0;
         q_p0   <= '0;
         vld_p0 <= 1'b0;
      end else if (en) begin
         pll_p0 <= mul16(a[15:0],  b[15:0]);
         plh_p0 <= mul16(a[15:0],  b[31:16]);
         phl_p0 <= mul16(a[31:16], b[15:0]);
         phh_p0 <= mul16(a[31:16], b[31:16]);
         q_p0   <= q;
         vld_p0 <= valid_in;
      end
   end

   // Stage p1: cross terms summed, carry kept in bit 32
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mid_p1 <= '0;
         pll_p1 <= '0;
         phh_p1 <= '0;
         q_p1   <= '0;
         vld_p1 <= 1'b0;
      end else if (en) begin
         mid_p1 <= {1'b0, plh_p0} + {1'b0, phl_p0};
         pll_p1 <= pll_p0;
         phh_p1 <= phh_p0;
         q_p1   <= q_p0;
         vld_p1 <= vld_p0;
      end
   end

   // Stage p2: final 64-bit combine; the true product always fits, so no carry out
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_p2   <= '0;
         q_p2   <= '0;
         vld_p2 <= 1'b0;
      end else if (en) begin
         d_p2   <= {phh_p1, 32'd0} + {15'd0, mid_p1, 16'd0} + {32'd0, pll_p1};
         q_p2   <= q_p1;
         vld_p2 <= vld_p1;
      end
   end

`ifdef INTMUL_OUT_REG_EN
   logic [63:0] d_p3;
   logic [31:0] q_p3;
   logic        vld_p3;

   // Stage p3: optional output register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_p3   <= '0;
         q_p3   <= '0;
         vld_p3 <= 1'b0;
      end else if (en) begin
         d_p3   <= d_p2;
         q_p3   <= q_p2;
         vld_p3 <= vld_p2;
      end
   end

   assign D         = d_p3;
   assign q_out     = q_p3;
   assign valid_out = vld_p3;
`else
   assign D         = d_p2;
   assign q_out     = q_p2;
   assign valid_out = vld_p2;
`endif

endmodule

// File: tb/tb_intmul_32.sv
// Directed bench for intmul_32; latency follows INTMUL_OUT_REG_EN.
module tb_intmul_32;

`ifdef INTMUL_OUT_REG_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] a = '0, b = '0, q = '0;
   logic        valid_out;
   logic [63:0] D;
   logic [31:0] q_out;

   int ncmp = 0;
   int nfail = 0;

   intmul_32 dut (
      .clk(clk), .rst(rst), .en(en), .valid_in(valid_in),
      .a(a), .b(b), .q(q),
      .valid_out(valid_out), .D(D), .q_out(q_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] qv);
      valid_in = v;
      a = av;
      b = bv;
      q = qv;
   endtask

   logic [63:0] d_hold;
   logic [63:0] exp_d;
   int j;

   initial begin
      // reset state
      tick();
      tick();
      chk("rst_valid", {63'd0, valid_out}, 64'd0);
      chk("rst_D", D, 64'd0);
      chk("rst_q", {32'd0, q_out}, 64'd0);
      #2 rst = 1'b1;
      en = 1'b1;
      tick();

      // all-ones operands, mid carry set
      drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
      tick();
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      for (int i = 0; i < LAT - 2; i++) tick();
      chk("t1_early", {63'd0, valid_out}, 64'd0);
      tick();
      chk("t1_valid", {63'd0, valid_out}, 64'd1);
      chk("t1_D", D, 64'hFFFF_FFFE_0000_0001);
      chk("t1_q", {32'd0, q_out}, 64'h0000_0000_FFFF_FFFB);
      tick();
      chk("t1_pulse", {63'd0, valid_out}, 64'd0);

      // mixed-half operands
      drive(1'b1, 32'h0001_FFFF, 32'hFFFF_0001, 32'h1234_5678);
      tick();
      drive(1'b1, 32'h0000_FFFF, 32'h0001_0000, 32'h0000_0011);
      tick();
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      for (int i = 0; i < LAT - 2; i++) tick();
      chk("t2a_valid", {63'd0, valid_out}, 64'd1);
      chk("t2a_D", D, 64'h0001_FFFD_0002_FFFF);
      chk("t2a_q", {32'd0, q_out}, 64'h0000_0000_1234_5678);
      tick();
      chk("t2b_valid", {63'd0, valid_out}, 64'd1);
      chk("t2b_D", D, 64'h0000_0000_FFFF_0000);
      chk("t2b_q", {32'd0, q_out}, 64'h0000_0000_0000_0011);
      for (int i = 0; i < LAT; i++) tick();

      // back-to-back stream a=i, b=i+1
      for (int t = 0; t < 8 + LAT; t++) begin
         if (t < 8) drive(1'b1, 32'(t + 1), 32'(t + 2), 32'h07E0_0001);
         else       drive(1'b0, 32'd0, 32'd0, 32'd0);
         tick();
         j = t - (LAT - 1);
         if (j >= 0 && j < 8) begin
            exp_d = 64'((j + 1) * (j + 2));
            chk("t3_valid", {63'd0, valid_out}, 64'd1);
            chk("t3_D", D, exp_d);
            chk("t3_q", {32'd0, q_out}, 64'h0000_0000_07E0_0001);
         end else begin
            chk("t3_idle", {63'd0, valid_out}, 64'd0);
         end
      end

      // stall with en=0 for 4 cycles after the issue cycle
      drive(1'b1, 32'd3, 32'd5, 32'h0000_00AA);
      tick();
      drive(1'b1, 32'd7, 32'd7, 32'd0);
      en = 1'b0;
      d_hold = D;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_stall_valid", {63'd0, valid_out}, 64'd0);
         chk("t4_stall_D", D, d_hold);
      end
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      en = 1'b1;
      for (int i = 0; i < LAT - 2; i++) tick();
      chk("t4_early", {63'd0, valid_out}, 64'd0);
      tick();
      chk("t4_valid", {63'd0, valid_out}, 64'd1);
      chk("t4_D", D, 64'd15);
      chk("t4_q", {32'd0, q_out}, 64'h0000_0000_0000_00AA);
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("t4_hold_valid", {63'd0, valid_out}, 64'd1);
         chk("t4_hold_D", D, 64'd15);
      end
      en = 1'b1;
      tick();
      chk("t4_after", {63'd0, valid_out}, 64'd0);

      // bubble pattern 1,0,1
      for (int t = 0; t < 3 + LAT; t++) begin
         if (t == 0)      drive(1'b1, 32'd100, 32'd200, 32'd9);
         else if (t == 1) drive(1'b0, 32'd55, 32'd55, 32'd9);
         else if (t == 2) drive(1'b1, 32'h0001_0000, 32'h0001_0000, 32'd9);
         else             drive(1'b0, 32'd0, 32'd0, 32'd0);
         tick();
         j = t - (LAT - 1);
         if (j == 0) begin
            chk("t6_v0", {63'd0, valid_out}, 64'd1);
            chk("t6_D0", D, 64'd20000);
         end else if (j == 1) begin
            chk("t6_v1", {63'd0, valid_out}, 64'd0);
         end else if (j == 2) begin
            chk("t6_v2", {63'd0, valid_out}, 64'd1);
            chk("t6_D2", D, 64'h0000_0001_0000_0000);
         end else begin
            chk("t6_idle", {63'd0, valid_out}, 64'd0);
         end
      end

      // asynchronous reset with two transactions in flight
      drive(1'b1, 32'd11, 32'd13, 32'd77);
      tick();
      drive(1'b1, 32'd17, 32'd19, 32'd77);
      tick();
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("t5_valid", {63'd0, valid_out}, 64'd0);
      chk("t5_D", D, 64'd0);
      chk("t5_q", {32'd0, q_out}, 64'd0);
      tick();
      #3 rst = 1'b1;
      for (int i = 0; i < LAT + 2; i++) begin
         tick();
         chk("t5_no_ghost", {63'd0, valid_out}, 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
